// File: rtl/cache_backing_mem_if.sv
// Request/response handshake bundle between the cache controller (master)
// and the backing memory (slave).
interface cache_backing_mem_if #(
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_write;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_write, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_write, resp_rdata
    );
endinterface

// File: rtl/cache_backing_mem.sv
// Word-addressed backing memory for data-cache refills and write-backs: one outstanding
// request, fixed LATENCY (1..15) from accept to response, valid/ready on both sides.
module cache_backing_mem #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 4
) (
    input  logic                clk,
    input  logic                rstn,
    cache_backing_mem_if.slave  bus,
    output logic [15:0]         rd_count,
    output logic [15:0]         wr_count
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam logic [3:0] LatInit = 4'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_write_q, resp_write_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic [15:0]         rd_count_q, rd_count_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic                mem_we;

    logic [DATA_W-1:0]   mem [2**ADDR_W];

    // Byte-lane and upper address bits are deliberately ignored (aliasing).
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_write_d = resp_write_q;
        resp_rdata_d = resp_rdata_q;
        rd_count_d   = rd_count_q;
        wr_count_d   = wr_count_q;
        mem_we       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid && req_ready_q) begin
                    addr_d      = bus.req_addr[ADDR_W+1:2];
                    write_d     = bus.req_write;
                    wdata_d     = bus.req_wdata;
                    cnt_d       = LatInit;
                    req_ready_d = 1'b0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Commit edge: the access and the response appear together.
                    resp_valid_d = 1'b1;
                    resp_write_d = write_q;
                    state_d      = StResp;
                    if (write_q) begin
                        mem_we     = 1'b1;
                        wr_count_d = wr_count_q + 16'd1;
                    end else begin
                        resp_rdata_d = mem[addr_q];
                        rd_count_d   = rd_count_q + 16'd1;
                    end
                end
            end
            StResp: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_rdata_q <= '0;
            rd_count_q   <= 16'd0;
            wr_count_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_write_q <= resp_write_d;
            resp_rdata_q <= resp_rdata_d;
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
        end
    end

    // Array has no reset; mem_we is only high in WAIT, so reset cancels a pending write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_write = resp_write_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign rd_count       = rd_count_q;
    assign wr_count       = wr_count_q;

endmodule
